// File: rtl/stack_ctrl_pkg.sv
// rtl/stack_ctrl_pkg.sv - shared types and constants for the stack-machine controller
//
// Holds the controller state encoding, the 4-bit opcode map and the
// fault_code values reported on the fault_code output.
package stack_ctrl_pkg;

   typedef enum logic [3:0] {
      S_INIT,
      S_FETCH,
      S_DECODE,
      S_ALU_1,
      S_ALU_2,
      S_PUSH_RD,
      S_PUSH_WR,
      S_POP_WR,
      S_JMP,
      S_JZ_1,
      S_JZ_2,
      S_HALT,
      S_FAULT
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_NOT  = 4'b0011;
   localparam logic [3:0] OP_PUSH = 4'b0100;
   localparam logic [3:0] OP_POP  = 4'b0101;
   localparam logic [3:0] OP_JMP  = 4'b0110;
   localparam logic [3:0] OP_JZ   = 4'b0111;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam logic [1:0] FC_NONE      = 2'b00;
   localparam logic [1:0] FC_UNDERFLOW = 2'b01;
   localparam logic [1:0] FC_OVERFLOW  = 2'b10;
   localparam logic [1:0] FC_ILLEGAL   = 2'b11;

   // The upper half of the opcode space is unused apart from HALT.
   function automatic logic is_illegal(input logic [3:0] op);
      return op[3] && (op != OP_HALT);
   endfunction

endpackage

// File: rtl/stack_depth_cnt.sv
// rtl/stack_depth_cnt.sv - stack occupancy tracker with push/pop headroom flags
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push, pop  occupancy +1 / -1 this cycle
//   depth      current occupancy, 0..STACK_DEPTH
//   can_pop1   at least one entry present
//   can_pop2   at least two entries present
//   can_push   room for one more entry
module stack_depth_cnt #(
   parameter int STACK_DEPTH = 16,
   localparam int DW = $clog2(STACK_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   output logic [DW-1:0] depth,
   output logic          can_pop1,
   output logic          can_pop2,
   output logic          can_push
);
   import stack_ctrl_pkg::*;

   localparam logic [DW-1:0] ONE  = DW'(1);
   localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

   // The controller never asserts push and pop together; if it ever did,
   // the two would cancel and occupancy would hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         depth <= '0;
      end else if (push && !pop) begin
         depth <= depth + ONE;
      end else if (pop && !push) begin
         depth <= depth - ONE;
      end
   end

   assign can_pop1 = (depth != '0);
   assign can_pop2 = (depth > ONE);
   assign can_push = (depth < FULL);

endmodule

// File: rtl/stack_ctrl_p.sv
// rtl/stack_ctrl_p.sv - multicycle control unit for the stack-machine datapath
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   inst                IR contents, opcode in the top four bits
//   zero                datapath zero flag of TOS
//   mem_ready           memory completes the current request this cycle
//   pc_src, ld_pc, ld_MDR, ld_IR, ld_B   datapath load/select strobes
//   mem_adr_src         1 = PC address, 0 = operand address
//   mem_req, mem_write  memory request and its write qualifier
//   stack_src           1 = ALU result, 0 = MDR
//   tos, stack_push, stack_pop            stack controls
//   alu_op              ALU function
//   halted, fault       sticky status
//   fault_code          01 underflow, 10 overflow, 11 illegal, 00 none
//   depth               current stack occupancy
module stack_ctrl_p #(
   parameter int INST_W = 8,
   parameter int STACK_DEPTH = 16,
   localparam int DW = $clog2(STACK_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [INST_W-1:0] inst,
   input  logic              zero,
   input  logic              mem_ready,
   output logic              pc_src,
   output logic              ld_pc,
   output logic              ld_MDR,
   output logic              ld_IR,
   output logic              ld_B,
   output logic              mem_adr_src,
   output logic              mem_req,
   output logic              mem_write,
   output logic              stack_src,
   output logic              tos,
   output logic              stack_push,
   output logic              stack_pop,
   output logic [1:0]        alu_op,
   output logic              halted,
   output logic              fault,
   output logic [1:0]        fault_code,
   output logic [DW-1:0]     depth
);
   import stack_ctrl_pkg::*;

   state_t     state;
   logic [1:0] fault_code_q;
   logic [1:0] dec_code;
   logic [3:0] opcode;
   logic       can_pop1;
   logic       can_pop2;
   logic       can_push;
   logic       unused_operand;

   assign opcode         = inst[INST_W-1 -: 4];
   assign unused_operand = ^inst[INST_W-5:0];
   assign fault_code     = fault_code_q;

   stack_depth_cnt #(
      .STACK_DEPTH(STACK_DEPTH)
   ) u_depth (
      .clk     (clk),
      .rst     (rst),
      .push    (stack_push),
      .pop     (stack_pop),
      .depth   (depth),
      .can_pop1(can_pop1),
      .can_pop2(can_pop2),
      .can_push(can_push)
   );

   // Decode-time checks, illegal opcode taking precedence over stack limits.
   always_comb begin
      dec_code = FC_NONE;
      if (is_illegal(opcode)) begin
         dec_code = FC_ILLEGAL;
      end else begin
         case (opcode)
            OP_ADD, OP_SUB, OP_AND: if (!can_pop2) dec_code = FC_UNDERFLOW;
            OP_NOT, OP_POP, OP_JZ:  if (!can_pop1) dec_code = FC_UNDERFLOW;
            OP_PUSH:                if (!can_push) dec_code = FC_OVERFLOW;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_INIT;
         fault_code_q <= FC_NONE;
      end else begin
         case (state)
            S_INIT:    state <= S_FETCH;
            S_FETCH:   if (mem_ready) state <= S_DECODE;
            S_DECODE: begin
               if (dec_code != FC_NONE) begin
                  state        <= S_FAULT;
                  fault_code_q <= dec_code;
               end else begin
                  case (opcode)
                     OP_ADD, OP_SUB, OP_AND: state <= S_ALU_1;
                     OP_NOT:                 state <= S_ALU_2;
                     OP_PUSH:                state <= S_PUSH_RD;
                     OP_POP:                 state <= S_POP_WR;
                     OP_JMP:                 state <= S_JMP;
                     OP_JZ:                  state <= S_JZ_1;
                     OP_HALT:                state <= S_HALT;
                     default:                state <= S_FAULT;
                  endcase
               end
            end
            S_ALU_1:   state <= S_ALU_2;
            S_ALU_2:   state <= S_FETCH;
            S_PUSH_RD: if (mem_ready) state <= S_PUSH_WR;
            S_PUSH_WR: state <= S_FETCH;
            S_POP_WR:  if (mem_ready) state <= S_FETCH;
            S_JMP:     state <= S_FETCH;
            S_JZ_1:    state <= zero ? S_JZ_2 : S_FETCH;
            S_JZ_2:    state <= S_FETCH;
            S_HALT:    state <= S_HALT;
            S_FAULT:   state <= S_FAULT;
            default:   state <= S_INIT;
         endcase
      end
   end

   // Strobes follow the state directly so a reset clears them at once;
   // completion strobes wait for mem_ready within the requesting state.
   always_comb begin
      pc_src      = 1'b0;
      ld_pc       = 1'b0;
      ld_MDR      = 1'b0;
      ld_IR       = 1'b0;
      ld_B        = 1'b0;
      mem_adr_src = 1'b0;
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      stack_src   = 1'b0;
      tos         = 1'b0;
      stack_push  = 1'b0;
      stack_pop   = 1'b0;
      alu_op      = 2'b00;
      halted      = 1'b0;
      fault       = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req     = 1'b1;
            mem_adr_src = 1'b1;
            ld_IR       = mem_ready;
            ld_pc       = mem_ready;
         end
         S_DECODE: begin
            // First operand leaves the stack here for ALU ops only.
            if (dec_code == FC_NONE &&
                (opcode == OP_ADD || opcode == OP_SUB ||
                 opcode == OP_AND || opcode == OP_NOT)) begin
               stack_pop = 1'b1;
               ld_B      = 1'b1;
            end
         end
         S_ALU_1: begin
            tos       = 1'b1;
            stack_pop = 1'b1;
         end
         S_ALU_2: begin
            alu_op     = opcode[1:0];
            tos        = 1'b1;
            stack_push = 1'b1;
            stack_src  = 1'b1;
         end
         S_PUSH_RD: begin
            mem_req = 1'b1;
            ld_MDR  = mem_ready;
         end
         S_PUSH_WR: stack_push = 1'b1;
         S_POP_WR: begin
            tos       = 1'b1;
            mem_req   = 1'b1;
            mem_write = 1'b1;
            stack_pop = mem_ready;
         end
         S_JMP, S_JZ_2: begin
            ld_pc  = 1'b1;
            pc_src = 1'b1;
         end
         S_JZ_1:  tos    = 1'b1;
         S_HALT:  halted = 1'b1;
         S_FAULT: fault  = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_stack_ctrl_p.sv
// tb/tb_stack_ctrl_p.sv - self-checking bench for stack_ctrl_p
//
// Two instances share all inputs: u0 (INST_W=8, STACK_DEPTH=4) and
// u1 (INST_W=16, STACK_DEPTH=16); sel chooses which one is compared.
module tb_stack_ctrl_p;
   import stack_ctrl_pkg::*;

   localparam logic [15:0] V_PC_SRC = 16'h8000;
   localparam logic [15:0] V_LD_PC  = 16'h4000;
   localparam logic [15:0] V_LD_MDR = 16'h2000;
   localparam logic [15:0] V_LD_IR  = 16'h1000;
   localparam logic [15:0] V_LD_B   = 16'h0800;
   localparam logic [15:0] V_ADR    = 16'h0400;
   localparam logic [15:0] V_REQ    = 16'h0200;
   localparam logic [15:0] V_WR     = 16'h0100;
   localparam logic [15:0] V_SRC    = 16'h0080;
   localparam logic [15:0] V_TOS    = 16'h0040;
   localparam logic [15:0] V_PUSH   = 16'h0020;
   localparam logic [15:0] V_POP    = 16'h0010;
   localparam logic [15:0] V_HALTED = 16'h0002;
   localparam logic [15:0] V_FAULT  = 16'h0001;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  inst0;
   logic [15:0] inst1;
   logic        zero;
   logic        mem_ready;

   logic [1:0] pc_src, ld_pc, ld_MDR, ld_IR, ld_B, mem_adr_src, mem_req;
   logic [1:0] mem_write, stack_src, tos, stack_push, stack_pop, halted, fault;
   logic [1:0] alu_op0, alu_op1, fault_code0, fault_code1;
   logic [2:0] depth0;
   logic [4:0] depth1;

   always #5 clk = ~clk;

   stack_ctrl_p #(.INST_W(8), .STACK_DEPTH(4)) u0 (
      .clk(clk), .rst(rst), .inst(inst0), .zero(zero), .mem_ready(mem_ready),
      .pc_src(pc_src[0]), .ld_pc(ld_pc[0]), .ld_MDR(ld_MDR[0]), .ld_IR(ld_IR[0]),
      .ld_B(ld_B[0]), .mem_adr_src(mem_adr_src[0]), .mem_req(mem_req[0]),
      .mem_write(mem_write[0]), .stack_src(stack_src[0]), .tos(tos[0]),
      .stack_push(stack_push[0]), .stack_pop(stack_pop[0]), .alu_op(alu_op0),
      .halted(halted[0]), .fault(fault[0]), .fault_code(fault_code0), .depth(depth0)
   );

   stack_ctrl_p #(.INST_W(16), .STACK_DEPTH(16)) u1 (
      .clk(clk), .rst(rst), .inst(inst1), .zero(zero), .mem_ready(mem_ready),
      .pc_src(pc_src[1]), .ld_pc(ld_pc[1]), .ld_MDR(ld_MDR[1]), .ld_IR(ld_IR[1]),
      .ld_B(ld_B[1]), .mem_adr_src(mem_adr_src[1]), .mem_req(mem_req[1]),
      .mem_write(mem_write[1]), .stack_src(stack_src[1]), .tos(tos[1]),
      .stack_push(stack_push[1]), .stack_pop(stack_pop[1]), .alu_op(alu_op1),
      .halted(halted[1]), .fault(fault[1]), .fault_code(fault_code1), .depth(depth1)
   );

   int          sel;
   logic [15:0] act_vec;
   logic [1:0]  act_code;
   int          act_depth;

   always_comb begin
      act_vec   = '0;
      act_code  = '0;
      act_depth = 0;
      if (sel == 0) begin
         act_vec = {pc_src[0], ld_pc[0], ld_MDR[0], ld_IR[0], ld_B[0], mem_adr_src[0],
                    mem_req[0], mem_write[0], stack_src[0], tos[0], stack_push[0],
                    stack_pop[0], alu_op0, halted[0], fault[0]};
         act_code  = fault_code0;
         act_depth = int'(depth0);
      end else begin
         act_vec = {pc_src[1], ld_pc[1], ld_MDR[1], ld_IR[1], ld_B[1], mem_adr_src[1],
                    mem_req[1], mem_write[1], stack_src[1], tos[1], stack_push[1],
                    stack_pop[1], alu_op1, halted[1], fault[1]};
         act_code  = fault_code1;
         act_depth = int'(depth1);
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: stack occupancy, capacity and sticky status of the compared instance.
   int          m_depth;
   int          m_cap;
   logic [1:0]  m_code;
   bit          m_halted;

   bit          chk = 1'b0;
   logic [15:0] exp_vec;
   logic [1:0]  exp_code;
   int          exp_depth;
   int          n_ld_ir;
   int          n_pop;

   always @(negedge clk) begin
      if (chk) begin
         check("outputs", int'(act_vec), int'(exp_vec));
         check("fault_code", int'(act_code), int'(exp_code));
         check("depth", act_depth, exp_depth);
         if (act_vec[12]) n_ld_ir++;
         if (act_vec[4]) n_pop++;
      end
   end

   // One clock cycle of expected outputs; occupancy moves on the closing edge.
   task automatic cyc(input logic [15:0] v, input logic mr);
      exp_vec   = v;
      exp_code  = m_code;
      exp_depth = m_depth;
      mem_ready = mr;
      chk       = 1'b1;
      @(posedge clk);
      #1;
      if ((v & V_PUSH) != 0) m_depth++;
      if ((v & V_POP) != 0) m_depth--;
   endtask

   task automatic set_inst(input logic [3:0] op);
      inst0 = {op, 4'h9};
      inst1 = {op, 12'hA5C};
   endtask

   task automatic fetch(input logic [3:0] op, input int fw);
      repeat (fw) cyc(V_REQ | V_ADR, 1'b0);
      cyc(V_REQ | V_ADR | V_LD_IR | V_LD_PC, 1'b1);
      set_inst(op);
   endtask

   // Whole instruction from FETCH entry: fw fetch waits, mw data waits.
   task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input logic z);
      int         need;
      logic [1:0] code;
      fetch(op, fw);
      zero = z;
      need = 0;
      if (op == OP_ADD || op == OP_SUB || op == OP_AND) need = 2;
      if (op == OP_NOT || op == OP_POP || op == OP_JZ) need = 1;
      if (op >= 4'd8 && op <= 4'd14)             code = 2'b11;
      else if (m_depth < need)                   code = 2'b01;
      else if (op == OP_PUSH && m_depth >= m_cap) code = 2'b10;
      else                                       code = 2'b00;
      if (code != 2'b00) begin
         cyc(16'h0, 1'b1);
         m_code = code;
         return;
      end
      case (op)
         OP_ADD, OP_SUB, OP_AND: begin
            cyc(V_POP | V_LD_B, 1'b1);
            cyc(V_TOS | V_POP, 1'b1);
            cyc({12'h0, op[1:0], 2'b00} | V_TOS | V_PUSH | V_SRC, 1'b1);
         end
         OP_NOT: begin
            cyc(V_POP | V_LD_B, 1'b1);
            cyc({12'h0, 2'b11, 2'b00} | V_TOS | V_PUSH | V_SRC, 1'b1);
         end
         OP_PUSH: begin
            cyc(16'h0, 1'b1);
            repeat (mw) cyc(V_REQ, 1'b0);
            cyc(V_REQ | V_LD_MDR, 1'b1);
            cyc(V_PUSH, 1'b1);
         end
         OP_POP: begin
            cyc(16'h0, 1'b1);
            repeat (mw) cyc(V_TOS | V_REQ | V_WR, 1'b0);
            cyc(V_TOS | V_REQ | V_WR | V_POP, 1'b1);
         end
         OP_JMP: begin
            cyc(16'h0, 1'b1);
            cyc(V_LD_PC | V_PC_SRC, 1'b1);
         end
         OP_JZ: begin
            cyc(16'h0, 1'b1);
            cyc(V_TOS, 1'b1);
            if (z) cyc(V_LD_PC | V_PC_SRC, 1'b1);
         end
         default: begin
            cyc(16'h0, 1'b1);
            m_halted = 1'b1;
         end
      endcase
   endtask

   task automatic hold(input int n);
      repeat (n) cyc(m_halted ? V_HALTED : V_FAULT, 1'b1);
   endtask

   task automatic do_reset(input int s);
      chk       = 1'b0;
      sel       = s;
      rst       = 1'b1;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      check("rst_outputs", int'(act_vec), 0);
      check("rst_depth", act_depth, 0);
      check("rst_code", int'(act_code), 0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      m_depth  = 0;
      m_code   = 2'b00;
      m_halted = 1'b0;
      m_cap    = (s == 0) ? 4 : 16;
      cyc(16'h0, 1'b1);
   endtask

   // Two pushes, then a PUSH stalled in its data read and reset between edges.
   task automatic reset_in_push_rd();
      run_instr(OP_PUSH, 0, 0, 1'b0);
      run_instr(OP_PUSH, 0, 0, 1'b0);
      fetch(OP_PUSH, 0);
      cyc(16'h0, 1'b1);
      cyc(V_REQ, 1'b0);
      exp_vec   = V_REQ;
      exp_code  = m_code;
      exp_depth = m_depth;
      @(negedge clk);
      #2;
      rst = 1'b1;
      chk = 1'b0;
      #1;
      check("async_rst_outputs", int'(act_vec), 0);
      check("async_rst_depth", act_depth, 0);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      m_depth = 0;
      m_code  = 2'b00;
      cyc(16'h0, 1'b1);
      run_instr(OP_PUSH, 0, 0, 1'b0);
      check("push_after_reset_depth", act_depth, 1);
   endtask

   initial begin
      zero  = 1'b0;
      inst0 = '0;
      inst1 = '0;
      n_ld_ir = 0;
      n_pop   = 0;

      // PUSH, PUSH, ADD with no wait states.
      do_reset(0);
      run_instr(OP_PUSH, 0, 0, 1'b0);
      check("depth_push1", act_depth, 1);
      run_instr(OP_PUSH, 0, 0, 1'b0);
      check("depth_push2", act_depth, 2);
      run_instr(OP_ADD, 0, 0, 1'b0);
      check("depth_add", act_depth, 1);

      // Wait states in FETCH and POP_WR.
      run_instr(OP_PUSH, 0, 1, 1'b0);
      n_ld_ir = 0;
      n_pop   = 0;
      run_instr(OP_POP, 3, 2, 1'b0);
      check("pop_ld_ir_pulses", n_ld_ir, 1);
      check("pop_stack_pop_pulses", n_pop, 1);
      check("depth_pop", act_depth, 1);

      // Branches and the remaining ALU ops.
      run_instr(OP_JZ, 0, 0, 1'b1);
      check("depth_jz_taken", act_depth, 1);
      run_instr(OP_JZ, 1, 0, 1'b0);
      check("depth_jz_not_taken", act_depth, 1);
      run_instr(OP_JMP, 0, 0, 1'b0);
      run_instr(OP_PUSH, 0, 0, 1'b0);
      run_instr(OP_SUB, 0, 0, 1'b0);
      run_instr(OP_NOT, 0, 0, 1'b0);
      run_instr(OP_PUSH, 2, 3, 1'b0);
      run_instr(OP_AND, 0, 0, 1'b0);
      check("depth_after_alu_mix", act_depth, 1);

      // Underflow: ADD with one entry.
      run_instr(OP_ADD, 0, 0, 1'b0);
      hold(5);
      check("underflow_code", int'(act_code), 1);

      // Overflow: fifth PUSH into a four-entry stack.
      do_reset(0);
      repeat (4) run_instr(OP_PUSH, 0, 0, 1'b0);
      run_instr(OP_PUSH, 0, 0, 1'b0);
      hold(4);
      check("overflow_code", int'(act_code), 2);
      check("overflow_depth", act_depth, 4);

      // Illegal opcode.
      do_reset(0);
      run_instr(4'b1010, 0, 0, 1'b0);
      hold(5);
      check("illegal_code", int'(act_code), 3);

      // HALT is absorbing.
      do_reset(0);
      run_instr(OP_HALT, 0, 0, 1'b0);
      hold(20);
      check("halted", int'(act_vec[1]), 1);

      // Asynchronous reset during a stalled PUSH_RD, both widths.
      do_reset(0);
      reset_in_push_rd();
      do_reset(1);
      reset_in_push_rd();
      run_instr(OP_PUSH, 0, 0, 1'b0);
      run_instr(OP_SUB, 0, 0, 1'b0);
      check("wide_depth_sub", act_depth, 1);

      chk = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
